multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Moore-style main controller for the multicycle RV32I core variant.
- Sequences the shared ALU, memory port, instruction register and register file over multiple cycles per instruction.
- Drives imm_src for the immediate extender: 00 I, 01 S, 10 B, 11 U/J.
- Inserts wait states on a memory ready handshake.

Parameters:
- STATE_W, 4, width of state register and debug state output

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- zero  in  1  ALU zero flag, combinational, current cycle
- mem_ready  in  1  memory access completes this cycle
- imm_src  out  2  immediate format select
- adr_src  out  1  0 = PC, 1 = ALUOut as memory address
- ir_write  out  1  load instruction register and OldPC
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
- alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
- alu_op  out  2  00 add, 01 subtract/compare, 10 funct-decoded
- result_src  out  2  00 ALUOut, 01 memory data, 10 ALU result
- pc_write  out  1  PC load enable
- reg_write  out  1  register file write enable
- mem_write  out  1  memory write strobe
- illegal_instr  out  1  one-cycle pulse on unsupported opcode
- state_dbg  out  STATE_W  current state encoding

Behaviour:
- State encodings: RST=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXECR=7, EXECI=8, ALUWB=9, BRANCH=10, JAL=11, LUI=12, AUIPC=13. Codes 14–15 are unreachable and recover to FETCH.
- rst_n low: state=RST immediately. All enables and selects = 0, illegal_instr=0.
- RST always moves to FETCH on the next edge.
- Unlisted outputs are 0 in every state.
- imm_src is combinational from opcode in every state:
  - 0000011 and 0010011 → 00
  - 0100011 → 01
  - 1100011 → 10
  - 0110111, 0010111, 1101111 → 11
  - any other opcode → 00
- FETCH: alu_src_a=00, alu_src_b=10, result_src=10.
  - ir_write = pc_write = mem_ready.
  - Stays in FETCH while mem_ready=0; moves to DECODE when mem_ready=1.
- DECODE: alu_src_a=01, alu_src_b=01 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 0110111 → LUI
  - 0010111 → AUIPC
  - else → FETCH, with illegal_instr=1 this cycle. JALR and SYSTEM are illegal in this revision.
- MEMADR: alu_src_a=10, alu_src_b=01. Next is MEMREAD if opcode[5]=0, MEMWRITE otherwise.
- MEMREAD: adr_src=1. Holds until mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1. Next FETCH.
- MEMWRITE: adr_src=1, mem_write=1. mem_write stays asserted until mem_ready, then FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. Next ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10. Next ALUWB.
- ALUWB: reg_write=1, result_src=00. Next FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - pc_write = zero XOR funct3[0], giving beq/bne.
  - Other funct3 values: pc_write=0. Next FETCH.
- JAL: alu_src_a=01, alu_src_b=10, result_src=00, pc_write=1. Next ALUWB.
- LUI: alu_src_a=11, alu_src_b=01. Next ALUWB.
- AUIPC: alu_src_a=01, alu_src_b=01. Next ALUWB.
- Latency in cycles with mem_ready tied high (FETCH included):
  - lw 5, sw 4
  - R-type, I-type, jal, lui, auipc 4
  - branch 3, illegal 2
- Each wait cycle adds exactly one cycle.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- Reset asserted mid-instruction: aborts within the same cycle. No write enable may remain high once rst_n=0.

Test Plan:
- rst_n low for 3 cycles, release → state_dbg 0 then 1; all enables 0 during reset.
- lw (0x00402083), mem_ready always 1 → states 1,2,3,4,5,1. imm_src=00, reg_write high only in state 5, result_src=01.
- sw (0x00112223), mem_ready low 2 cycles in MEMWRITE → mem_write high 3 consecutive cycles, imm_src=01, return to FETCH.
- beq (0x00208463) with zero=1 → pc_write=1 in BRANCH; repeat with zero=0 → pc_write=0. bne (funct3=001) with zero=0 → pc_write=1.
- lui (0x123450B7) → states 1,2,12,9. alu_src_a=11, imm_src=11, reg_write in ALUWB.
- opcode 1100111 (jalr) → illegal_instr pulses one cycle in DECODE, then FETCH. Separately, rst_n dropped during MEMWRITE → mem_write=0 in the same cycle, state_dbg=0.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Main controller for the multicycle RV32I core: sequences ALU, memory port,
// instruction register and register file, with wait states on mem_ready.
module multicycle_ctrl_fsm #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic               zero,
    input  logic               mem_ready,
    output logic [1:0]         imm_src,
    output logic               adr_src,
    output logic               ir_write,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         result_src,
    output logic               pc_write,
    output logic               reg_write,
    output logic               mem_write,
    output logic               illegal_instr,
    output logic [STATE_W-1:0] state_dbg
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13
    } state_t;

    state_t state;
    state_t state_next;

    // Async reset forces RST, whose decode drops every enable in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RST;
        end else begin
            state <= state_next;
        end
    end

    assign state_dbg = STATE_W'(state);

    // Immediate format follows the opcode regardless of state.
    always_comb begin
        imm_src = 2'b00;
        case (opcode)
            OP_STORE:                 imm_src = 2'b01;
            OP_BRANCH:                imm_src = 2'b10;
            OP_LUI, OP_AUIPC, OP_JAL: imm_src = 2'b11;
            default:                  imm_src = 2'b00;
        endcase
    end

    always_comb begin
        state_next    = S_FETCH;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        result_src    = 2'b00;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        mem_write     = 1'b0;
        illegal_instr = 1'b0;
        case (state)
            S_RST: state_next = S_FETCH;
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                state_next = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_AUIPC;
                    default: begin
                        state_next    = S_FETCH;
                        illegal_instr = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                state_next = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                state_next = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                // Only beq/bne are resolved; other conditions never redirect.
                pc_write  = (funct3[2:1] == 2'b00) ? (zero ^ funct3[0]) : 1'b0;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write   = 1'b1;
                state_next = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a  = 2'b11;
                alu_src_b  = 2'b01;
                state_next = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b01;
                state_next = S_ALUWB;
            end
            default: state_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed, table-driven bench for multicycle_ctrl_fsm: one vector per cycle,
// plus hand-written reset sequences.
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic [1:0] imm_src;
    logic       adr_src;
    logic       ir_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       illegal_instr;
    logic [3:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    multicycle_ctrl_fsm #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .zero(zero), .mem_ready(mem_ready), .imm_src(imm_src),
        .adr_src(adr_src), .ir_write(ir_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
        .pc_write(pc_write), .reg_write(reg_write), .mem_write(mem_write),
        .illegal_instr(illegal_instr), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;

    typedef struct packed {
        logic [6:0] opc;
        logic [2:0] f3;
        logic       z;
        logic       mr;
        logic [3:0] st;
        logic [1:0] imm;
        logic       adr;
        logic       irw;
        logic [1:0] asa;
        logic [1:0] asb;
        logic [1:0] aop;
        logic [1:0] rs;
        logic       pcw;
        logic       rw;
        logic       mw;
        logic       ill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [6:0] opc, logic [2:0] f3, logic z, logic mr,
                                logic [3:0] st, logic [1:0] imm, logic adr, logic irw,
                                logic [1:0] asa, logic [1:0] asb, logic [1:0] aop,
                                logic [1:0] rs, logic pcw, logic rw, logic mw, logic ill);
        vec_t v;
        v = '{opc, f3, z, mr, st, imm, adr, irw, asa, asb, aop, rs, pcw, rw, mw, ill};
        return v;
    endfunction

    function automatic logic [19:0] got_outputs();
        return {state_dbg, imm_src, adr_src, ir_write, alu_src_a, alu_src_b,
                alu_op, result_src, pc_write, reg_write, mem_write, illegal_instr};
    endfunction

    function automatic logic [19:0] exp_outputs(vec_t v);
        return {v.st, v.imm, v.adr, v.irw, v.asa, v.asb, v.aop, v.rs,
                v.pcw, v.rw, v.mw, v.ill};
    endfunction

    task automatic check(string name, logic [19:0] got, logic [19:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b required %b (st imm adr irw asa asb aop rs pcw rw mw ill)",
                     name, got, exp);
        end
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; opcode = 7'd0; funct3 = 3'd0; zero = 1'b0; mem_ready = 1'b1;

        // Reset held for three cycles: RST state, everything low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check($sformatf("reset_hold%0d", i), got_outputs(), 20'd0);
        end
        @(posedge clk); #2 rst_n = 1'b1;

        //                opc  f3    z   mr  st     imm   adr  irw  asa    asb    aop    rs     pcw  rw   mw   ill
        // lw x1,4(x0)
        vecs.push_back(mk(LW, 3'd2, 0, 1, 4'd0,  2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(LW, 3'd2, 0, 1, 4'd1,  2'b00, 0, 1, 2'b00, 2'b10, 2'b00, 2'b10, 1, 0, 0, 0));
        vecs.push_back(mk(LW, 3'd2, 0, 1, 4'd2,  2'b00, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(LW, 3'd2, 0, 1, 4'd3,  2'b00, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(LW, 3'd2, 0, 1, 4'd4,  2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(LW, 3'd2, 0, 1, 4'd5,  2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 1, 0, 0));
        // sw with a fetch wait state and two MEMWRITE wait states
        vecs.push_back(mk(SW, 3'd2, 0, 0, 4'd1,  2'b01, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 0, 0));
        vecs.push_back(mk(SW, 3'd2, 0, 1, 4'd1,  2'b01, 0, 1, 2'b00, 2'b10, 2'b00, 2'b10, 1, 0, 0, 0));
        vecs.push_back(mk(SW, 3'd2, 0, 1, 4'd2,  2'b01, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(SW, 3'd2, 0, 0, 4'd3,  2'b01, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(SW, 3'd2, 0, 0, 4'd6,  2'b01, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0));
        vecs.push_back(mk(SW, 3'd2, 0, 0, 4'd6,  2'b01, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0));
        vecs.push_back(mk(SW, 3'd2, 0, 1, 4'd6,  2'b01, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0));
        // beq taken (mem_ready low in DECODE is ignored)
        vecs.push_back(mk(BR, 3'd0, 1, 1, 4'd1,  2'b10, 0, 1, 2'b00, 2'b10, 2'b00, 2'b10, 1, 0, 0, 0));
        vecs.push_back(mk(BR, 3'd0, 1, 0, 4'd2,  2'b10, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(BR, 3'd0, 1, 1, 4'd10, 2'b10, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00, 1, 0, 0, 0));
        // beq not taken
        vecs.push_back(mk(BR, 3'd0, 0, 1, 4'd1,  2'b10, 0, 1, 2'b00, 2'b10, 2'b00, 2'b10, 1, 0, 0, 0));
        vecs.push_back(mk(BR, 3'd0, 0, 1, 4'd2,  2'b10, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(BR, 3'd0, 0, 1, 4'd10, 2'b10, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0));
        // bne taken
        vecs.push_back(mk(BR, 3'd1, 0, 1, 4'd1,  2'b10, 0, 1, 2'b00, 2'b10, 2'b00, 2'b10, 1, 0, 0, 0));
        vecs.push_back(mk(BR, 3'd1, 0, 1, 4'd2,  2'b10, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(BR, 3'd1, 0, 1, 4'd10, 2'b10, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00, 1, 0, 0, 0));
        // blt: unsupported condition never redirects
        vecs.push_back(mk(BR, 3'd4, 1, 1, 4'd1,  2'b10, 0, 1, 2'b00, 2'b10, 2'b00, 2'b10, 1, 0, 0, 0));
        vecs.push_back(mk(BR, 3'd4, 1, 1, 4'd2,  2'b10, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(BR, 3'd4, 1, 1, 4'd10, 2'b10, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0));
        // lui x1,0x12345
        vecs.push_back(mk(LUI, 3'd0, 0, 1, 4'd1,  2'b11, 0, 1, 2'b00, 2'b10, 2'b00, 2'b10, 1, 0, 0, 0));
        vecs.push_back(mk(LUI, 3'd0, 0, 1, 4'd2,  2'b11, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(LUI, 3'd0, 0, 1, 4'd12, 2'b11, 0, 0, 2'b11, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(LUI, 3'd0, 0, 1, 4'd9,  2'b11, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0));
        // R-type add
        vecs.push_back(mk(RT, 3'd0, 0, 1, 4'd1,  2'b00, 0, 1, 2'b00, 2'b10, 2'b00, 2'b10, 1, 0, 0, 0));
        vecs.push_back(mk(RT, 3'd0, 0, 1, 4'd2,  2'b00, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(RT, 3'd0, 0, 1, 4'd7,  2'b00, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(RT, 3'd0, 0, 1, 4'd9,  2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0));
        // jal
        vecs.push_back(mk(JAL, 3'd0, 0, 1, 4'd1,  2'b11, 0, 1, 2'b00, 2'b10, 2'b00, 2'b10, 1, 0, 0, 0));
        vecs.push_back(mk(JAL, 3'd0, 0, 1, 4'd2,  2'b11, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(JAL, 3'd0, 0, 1, 4'd11, 2'b11, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 1, 0, 0, 0));
        vecs.push_back(mk(JAL, 3'd0, 0, 1, 4'd9,  2'b11, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0));
        // jalr is illegal: one-cycle pulse in DECODE, back to FETCH
        vecs.push_back(mk(JALR, 3'd0, 0, 1, 4'd1, 2'b00, 0, 1, 2'b00, 2'b10, 2'b00, 2'b10, 1, 0, 0, 0));
        vecs.push_back(mk(JALR, 3'd0, 0, 1, 4'd2, 2'b00, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 1));
        vecs.push_back(mk(JALR, 3'd0, 0, 0, 4'd1, 2'b00, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            opcode = vecs[i].opc; funct3 = vecs[i].f3;
            zero = vecs[i].z;     mem_ready = vecs[i].mr;
            #1;
            check($sformatf("vec%0d", i), got_outputs(), exp_outputs(vecs[i]));
        end

        // Drive a store into MEMWRITE and stall it there (bounded wait).
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            opcode = SW; funct3 = 3'd2; mem_ready = 1'b1;
            #1;
            if (state_dbg == 4'd6) begin
                mem_ready = 1'b0;
                found = 1'b1;
            end
        end
        check("reach_memwrite", {19'd0, found}, 20'd1);
        check("memwrite_stalled", {19'd0, mem_write}, 20'd1);

        // Reset between clock edges aborts the write immediately.
        #2 rst_n = 1'b0;
        #1;
        check("async_abort", {state_dbg, 2'b00, adr_src, ir_write, alu_src_a, alu_src_b,
                              alu_op, result_src, pc_write, reg_write, mem_write, illegal_instr},
              20'd0);

        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk); #1;
        check("post_abort_rst", {16'd0, state_dbg}, 20'd0);
        @(negedge clk); #1;
        check("post_abort_fetch", {16'd0, state_dbg}, 20'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
